// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: single-outstanding imem prefetcher with a small {pc, word, fault} FIFO and redirect drain
module instr_prefetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200,
  parameter int DEPTH = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        imem_ren,
  output logic [31:0] imem_addr,
  input  logic        imem_busy,
  input  logic [31:0] imem_rdata,
  input  logic        imem_fault,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault,
  output logic        instr_valid
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
  state_t state, state_n;
  logic [31:0] req_pc, req_pc_n, next_pc, next_pc_n, pend_pc, pend_pc_n, rpc, inc_pc;
  logic [31:0] pc_q [DEPTH];
  logic [31:0] word_q [DEPTH];
  logic fault_q [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_n;
  logic done, push, pop, issue;
  assign rpc = {redirect_pc[31:2], 2'b00};
  assign inc_pc = req_pc + 32'd4;
  assign imem_ren = state != IDLE;
  assign imem_addr = req_pc;
  assign instr_valid = count != '0;
  assign instr = instr_valid ? word_q[rd_ptr] : 32'h0000_0013;
  assign instr_pc = instr_valid ? pc_q[rd_ptr] : 32'h0;
  assign instr_fault = instr_valid && fault_q[rd_ptr];
  assign done = imem_ren && !imem_busy;
  assign push = state == REQ && done && !redirect;
  assign pop = instr_valid && !stall && !redirect;
  assign count_n = redirect ? '0 : count + CW'(push) - CW'(pop);
  assign issue = !halt && count_n < CW'(DEPTH);
  always_comb begin
    state_n = state;
    req_pc_n = req_pc;
    next_pc_n = next_pc;
    pend_pc_n = pend_pc;
    case (state)
      IDLE: begin
        if (redirect) next_pc_n = rpc;
        if (issue) begin
          req_pc_n = redirect ? rpc : next_pc;
          state_n = REQ;
        end
      end
      REQ: begin
        if (done && redirect) begin
          next_pc_n = rpc;
          req_pc_n = rpc;
          state_n = halt ? IDLE : REQ;
        end else if (done) begin
          next_pc_n = inc_pc;
          req_pc_n = issue ? inc_pc : req_pc;
          state_n = issue ? REQ : IDLE;
        end else if (redirect) begin
          pend_pc_n = rpc;
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (!done) begin
          pend_pc_n = redirect ? rpc : pend_pc;
        end else if (!halt && !redirect) begin
          req_pc_n = pend_pc;
          state_n = REQ;
        end else begin
          next_pc_n = redirect ? rpc : pend_pc;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      req_pc <= RESET_PC;
      next_pc <= RESET_PC;
      pend_pc <= RESET_PC;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_n;
      req_pc <= req_pc_n;
      next_pc <= next_pc_n;
      pend_pc <= pend_pc_n;
      count <= count_n;
      rd_ptr <= redirect ? '0 : rd_ptr + AW'(pop);
      wr_ptr <= redirect ? '0 : wr_ptr + AW'(push);
    end
  end
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_q[wr_ptr] <= req_pc;
      word_q[wr_ptr] <= imem_rdata;
      fault_q[wr_ptr] <= imem_fault;
    end
  end
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb_instr_prefetch_buffer: directed stimulus checked against a queue-based fetch model plus literal expectations
module tb_instr_prefetch_buffer;
  localparam logic [31:0] RPC = 32'h0000_0200;
  localparam int DEPTH = 2;
  logic CLK = 0, nRST = 0, imem_busy = 0, redirect = 0, halt = 0, stall = 0;
  logic [31:0] redirect_pc = 0, fault_addr = 32'hFFFF_FFFF;
  logic imem_ren, imem_fault, instr_fault, instr_valid;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction
  assign imem_rdata = mem_word(imem_addr);
  assign imem_fault = imem_addr == fault_addr;
  instr_prefetch_buffer #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .imem_ren(imem_ren), .imem_addr(imem_addr),
    .imem_busy(imem_busy), .imem_rdata(imem_rdata), .imem_fault(imem_fault),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .stall(stall),
    .instr(instr), .instr_pc(instr_pc), .instr_fault(instr_fault), .instr_valid(instr_valid)
  );
  always #5 CLK = ~CLK;
  int vecs = 0, errs = 0;
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  typedef struct {logic [31:0] pc; logic [31:0] w; logic f;} ent_t;
  ent_t q[$];
  bit m_live = 0, m_busy = 0, m_drop = 0, m_done = 0;
  logic [31:0] m_addr = 0, m_next = 0, m_pend = 0, m_rp = 0;
  always @(posedge CLK) begin
    if (!nRST) begin
      q.delete();
      m_busy = 0;
      m_drop = 0;
      m_next = RPC;
      m_live = 1;
    end else begin
      m_rp = {redirect_pc[31:2], 2'b00};
      m_done = m_busy && !imem_busy;
      if (redirect) q.delete();
      else begin
        if (q.size() != 0 && !stall) void'(q.pop_front());
        if (m_done && !m_drop) q.push_back('{m_addr, mem_word(m_addr), m_addr == fault_addr});
      end
      if (!m_busy) begin
        if (redirect) m_next = m_rp;
        if (!halt && q.size() < DEPTH) begin
          m_addr = m_next;
          m_busy = 1;
        end
      end else if (m_done && m_drop) begin
        m_drop = 0;
        if (!halt && !redirect) m_addr = m_pend;
        else begin
          m_busy = 0;
          m_next = redirect ? m_rp : m_pend;
        end
      end else if (m_done && redirect) begin
        m_next = m_rp;
        m_addr = m_rp;
        m_busy = !halt;
      end else if (m_done) begin
        m_next = m_addr + 32'd4;
        if (!halt && q.size() < DEPTH) m_addr = m_next;
        else m_busy = 0;
      end else if (redirect) begin
        m_drop = 1;
        m_pend = m_rp;
      end
    end
  end
  always @(negedge CLK) begin
    if (m_live) begin
      check("imem_ren", imem_ren, m_busy);
      if (m_busy) check("imem_addr", imem_addr, m_addr);
      check("addr_align", imem_addr[1:0], 0);
      check("instr_valid", instr_valid, q.size() != 0);
      if (q.size() != 0) begin
        check("instr", instr, q[0].w);
        check("instr_pc", instr_pc, q[0].pc);
        check("instr_fault", instr_fault, q[0].f);
      end else begin
        check("instr_empty", instr, 32'h0000_0013);
        check("instr_pc_empty", instr_pc, 0);
        check("instr_fault_empty", instr_fault, 0);
      end
    end
  end
  task automatic step(input logic b = 0, input logic s = 0, input logic r = 0, input logic h = 0, input logic [31:0] pc = 0);
    imem_busy = b;
    stall = s;
    redirect = r;
    halt = h;
    redirect_pc = pc;
    @(negedge CLK);
  endtask
  task automatic reset_dut();
    nRST = 0;
    step();
    step();
    check("rst_ren", imem_ren, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_pc", instr_pc, 0);
    nRST = 1;
  endtask
  initial begin
    @(negedge CLK);
    reset_dut();
    step();
    check("s1_addr0", imem_addr, 32'h200);
    check("s1_valid0", instr_valid, 0);
    step();
    check("s1_valid1", instr_valid, 1);
    check("s1_pc0", instr_pc, 32'h200);
    check("s1_addr1", imem_addr, 32'h204);
    step();
    check("s1_pc1", instr_pc, 32'h204);
    check("s1_addr2", imem_addr, 32'h208);
    repeat (3) step();
    reset_dut();
    repeat (3) step(0, 1);
    check("s2_ren_off", imem_ren, 0);
    check("s2_head", instr_pc, 32'h200);
    step(0, 1);
    step(0, 1);
    check("s2_still_off", imem_ren, 0);
    step();
    check("s2_resume", imem_addr, 32'h208);
    check("s2_head2", instr_pc, 32'h204);
    step();
    check("s2_head3", instr_pc, 32'h208);
    reset_dut();
    step();
    step();
    step(1, 0, 1, 0, 32'h1000);
    check("s3_hold", imem_addr, 32'h204);
    check("s3_flushed", instr_valid, 0);
    step(1);
    step(1);
    check("s3_hold2", imem_addr, 32'h204);
    step();
    check("s3_restart", imem_addr, 32'h1000);
    check("s3_nodata", instr_valid, 0);
    step();
    check("s3_first", instr_pc, 32'h1000);
    reset_dut();
    repeat (3) step();
    check("s4_addr", imem_addr, 32'h208);
    step(0, 0, 1, 0, 32'h1000);
    check("s4_empty", instr_valid, 0);
    check("s4_addr2", imem_addr, 32'h1000);
    step();
    check("s4_first", instr_pc, 32'h1000);
    reset_dut();
    step();
    step(1, 0, 1, 0, 32'h2000);
    step(1, 0, 1, 0, 32'h3000);
    check("s5_hold", imem_addr, 32'h200);
    step();
    check("s5_restart", imem_addr, 32'h3000);
    step();
    check("s5_first", instr_pc, 32'h3000);
    reset_dut();
    step();
    step(0, 1, 0, 1);
    check("s6_ren_off", imem_ren, 0);
    check("s6_kept", instr_pc, 32'h200);
    step(0, 1, 0, 1);
    check("s6_kept2", instr_valid, 1);
    step(0, 1, 1, 1, 32'h43);
    check("s6_flush", instr_valid, 0);
    check("s6_no_req", imem_ren, 0);
    step();
    check("s6_addr", imem_addr, 32'h40);
    check("s6_ren", imem_ren, 1);
    fault_addr = 32'h20C;
    reset_dut();
    repeat (5) step();
    check("f_pc", instr_pc, 32'h20C);
    check("f_fault", instr_fault, 1);
    check("f_word", instr, 32'h115B_662C);
    step();
    check("f_clear", instr_fault, 0);
    fault_addr = 32'hFFFF_FFFF;
    reset_dut();
    step(0, 0, 1, 0, 32'hFFFF_FFF9);
    check("w_addr0", imem_addr, 32'hFFFF_FFF8);
    step();
    check("w_addr1", imem_addr, 32'hFFFF_FFFC);
    step();
    check("w_wrap", imem_addr, 32'h0);
    for (int i = 0; i < 300; i++)
      step(i % 3 == 1 || i % 7 == 2, i % 5 > 2, i % 17 == 7 || i % 29 == 3, i % 23 > 19, 32'h800 + 32'(i * 12) + 32'(i % 4));
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
